// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : program counter, req/ack fetch and branch-resolve sequencer
// Revision     : 1.0
// ============================================================================
module pc_sequencer #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 16,
  parameter int              CMP_W    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               is_branch,
  input  logic               halt,
  input  logic               br_valid,
  input  logic [1:0]         pc_op,
  input  logic [CMP_W-1:0]   cmp_res,
  input  logic [PC_W-1:0]    br_target,
  output logic [PC_W-1:0]    pc,
  output logic               pc_mux_sel,
  output logic               halted,
  output logic [15:0]        retired_cnt
);

  typedef enum logic [2:0] {
    S_BOOT    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_RESOLVE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [PC_W-1:0]      r_pc;
  logic [INSTR_W-1:0]   r_instr;
  logic [15:0]          r_retired;
  logic                 r_mux_sel;
  logic [PC_W-1:0]      w_pc_inc;
  logic                 w_taken;

  // Natural-width add wraps modulo 2^PC_W.
  assign w_pc_inc = r_pc + 1'b1;

  always_comb begin
    w_taken = 1'b0;
    case (pc_op)
      2'b00:   w_taken = 1'b0;
      2'b01:   w_taken = 1'b1;
      2'b10:   w_taken = (cmp_res != '0);
      2'b11:   w_taken = (cmp_res == '0);
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_next;
    end
  end

  // Inputs are only looked at in the state that owns them; HALT has no exit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT:    w_next = S_FETCH;
      S_FETCH:   if (imem_ack) w_next = S_ISSUE;
      S_ISSUE: begin
        if (instr_ready) begin
          if (halt)           w_next = S_HALT;
          else if (is_branch) w_next = S_RESOLVE;
          else                w_next = S_FETCH;
        end
      end
      S_RESOLVE: if (br_valid) w_next = S_FETCH;
      S_HALT:    w_next = S_HALT;
      default:   w_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_retired <= '0;
      r_mux_sel <= 1'b0;
    end else begin
      r_mux_sel <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (imem_ack) r_instr <= imem_data;
        end
        S_ISSUE: begin
          if (instr_ready) begin
            r_retired <= r_retired + 16'd1;
            if (!halt && !is_branch) r_pc <= w_pc_inc;
          end
        end
        S_RESOLVE: begin
          if (br_valid) begin
            r_pc      <= w_taken ? br_target : w_pc_inc;
            r_mux_sel <= w_taken;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign retired_cnt = r_retired;
  assign pc_mux_sel  = r_mux_sel;
  assign imem_req    = (r_state == S_FETCH);
  assign instr_valid = (r_state == S_ISSUE);
  assign halted      = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// Testbench for pc_sequencer: memory/decoder/datapath responders feed the DUT,
// expected fetches go into a queue that a negedge monitor pops and checks.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        is_branch = 1'b0;
  logic        halt = 1'b0;
  logic        br_valid = 1'b0;
  logic [1:0]  pc_op = '0;
  logic [7:0]  cmp_res = '0;
  logic [7:0]  br_target = '0;
  logic [7:0]  pc;
  logic        pc_mux_sel;
  logic        halted;
  logic [15:0] retired_cnt;

  always #5 clk = ~clk;

  pc_sequencer #(.PC_W(8), .INSTR_W(16), .CMP_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .is_branch(is_branch), .halt(halt),
    .br_valid(br_valid), .pc_op(pc_op), .cmp_res(cmp_res), .br_target(br_target),
    .pc(pc), .pc_mux_sel(pc_mux_sel), .halted(halted), .retired_cnt(retired_cnt)
  );

  typedef struct {
    logic [7:0] addr;
    logic       pulse;
    int         cyc;     // -1: start cycle not checked
  } fetch_t;

  fetch_t      exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Program image: bit15 = branch, bit14 = halt, low byte = own address.
  logic [15:0] mem    [256];
  logic [1:0]  br_op  [256];
  logic [7:0]  br_cmp [256];
  logic [7:0]  br_tgt [256];
  int          ack_delay = 0, ready_delay = 0, br_delay = 0;
  logic        noisy = 1'b0, force_br = 1'b0, mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] mk(input int a, input logic br, input logic h);
    return {br, h, 6'h2A, 8'(a)};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      mem[i] = mk(i, 1'b0, 1'b0);
      br_op[i] = 2'b00; br_cmp[i] = 8'h00; br_tgt[i] = 8'h00;
    end
  endtask

  // Responders for memory, decoder and datapath, updated just after each edge.
  int         fw = 0, rw = 0, bw = 0;
  logic       in_res = 1'b0;
  logic [7:0] res_addr = '0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        fw = 0; rw = 0; bw = 0; in_res = 1'b0;
        imem_ack = 1'b0; imem_data = 16'hDEAD;
        instr_ready = 1'b0; is_branch = 1'b0; halt = 1'b0;
        br_valid = force_br; pc_op = 2'b01; cmp_res = 8'h00; br_target = 8'h77;
      end else begin
        if (in_res) begin
          pc_op = br_op[res_addr]; cmp_res = br_cmp[res_addr]; br_target = br_tgt[res_addr];
          if (bw >= br_delay) begin br_valid = 1'b1; in_res = 1'b0; end
          else begin br_valid = 1'b0; bw++; end
        end else begin
          br_valid = noisy; pc_op = 2'b01; cmp_res = 8'h00; br_target = 8'hEE;
        end
        if (force_br) begin
          br_valid = 1'b1; pc_op = 2'b01; br_target = 8'h77;
        end
        if (imem_req) begin
          if (fw >= ack_delay) begin imem_ack = 1'b1; imem_data = mem[imem_addr]; fw = 0; end
          else begin imem_ack = 1'b0; imem_data = 16'hDEAD; fw++; end
        end else begin
          imem_ack = noisy; imem_data = 16'hDEAD; fw = 0;
        end
        if (instr_valid) begin
          is_branch = instr[15]; halt = instr[14];
          if (rw >= ready_delay) begin
            instr_ready = 1'b1; rw = 0;
            if (instr[15] && !instr[14]) begin in_res = 1'b1; bw = 0; res_addr = pc; end
          end else begin
            instr_ready = 1'b0; rw++;
          end
        end else begin
          instr_ready = noisy; is_branch = noisy; halt = noisy; rw = 0;
        end
      end
    end
  end

  // Monitor: pops an expected fetch on the first cycle of every FETCH.
  int          cyc = 0, model_cnt = 0;
  logic        prev_req = 1'b0;
  logic [7:0]  hold_addr = '0;
  logic [15:0] cap_instr = '0;
  fetch_t      e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        cyc = 0; model_cnt = 0; prev_req = 1'b0;
      end else begin
        cyc++;
        if (imem_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_fetch: got addr 0x%0h, required no fetch", imem_addr);
          end else begin
            e = exp_q.pop_front();
            check("fetch_addr", 32'(imem_addr), 32'(e.addr));
            check("mux_pulse", 32'(pc_mux_sel), 32'(e.pulse));
            if (e.cyc >= 0) check("fetch_cycle", 32'(cyc), 32'(e.cyc));
          end
          hold_addr = imem_addr;
        end else if (imem_req) begin
          check("addr_hold", 32'(imem_addr), 32'(hold_addr));
          check("mux_low_fetch", 32'(pc_mux_sel), 32'd0);
        end
        if (imem_req && imem_ack) cap_instr = imem_data;
        if (instr_valid) begin
          check("instr_stable", 32'(instr), 32'(cap_instr));
          check("retired", 32'(retired_cnt), model_cnt);
          check("mux_low_issue", 32'(pc_mux_sel), 32'd0);
          if (instr_ready) model_cnt++;
        end
        prev_req = imem_req;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1; mon_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", 32'(pc), 32'h00);
    check("rst_instr", 32'(instr), 32'h0);
    check("rst_retired", 32'(retired_cnt), 32'h0);
    check("rst_flags", {28'd0, imem_req, instr_valid, halted, pc_mux_sel}, 32'h0);
    @(posedge clk); #2;
    force_br = 1'b0; rst = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    check("boot_idle", {30'd0, imem_req, halted}, 32'h0);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_halt(input int budget, input int n_ret);
    for (int i = 0; i < budget && !halted; i++) @(negedge clk);
    check("halted", 32'(halted), 32'd1);
    check("retired_final", 32'(retired_cnt), 32'(n_ret));
    repeat (4) begin
      @(negedge clk);
      check("halt_quiet", {30'd0, imem_req, halted}, 32'h1);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic p, input int c);
    exp_q.push_back('{addr: a, pulse: p, cyc: c});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_prog();

    // Straight-line code, zero-wait handshakes, noise on idle inputs.
    noisy = 1'b1;
    mem[3] = mk(3, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) push(8'(i), 1'b0, 2 + 2 * i);
    wait_drain(50);
    wait_halt(20, 4);

    // Each jump opcode, taken and not taken; halt beats branch.
    clear_prog();
    br_delay = 3;
    mem[8'h05] = mk(8'h05, 1, 0); br_op[8'h05] = 2'b01; br_tgt[8'h05] = 8'h40;
    mem[8'h40] = mk(8'h40, 1, 0); br_op[8'h40] = 2'b10; br_tgt[8'h40] = 8'h99;
    mem[8'h41] = mk(8'h41, 1, 0); br_op[8'h41] = 2'b11; br_tgt[8'h41] = 8'h10;
    mem[8'h11] = mk(8'h11, 1, 0); br_op[8'h11] = 2'b10; br_cmp[8'h11] = 8'h03; br_tgt[8'h11] = 8'h20;
    mem[8'h20] = mk(8'h20, 1, 0); br_op[8'h20] = 2'b11; br_cmp[8'h20] = 8'h05; br_tgt[8'h20] = 8'h60;
    mem[8'h21] = mk(8'h21, 1, 0); br_op[8'h21] = 2'b00; br_tgt[8'h21] = 8'h30;
    mem[8'h22] = mk(8'h22, 1, 1); br_op[8'h22] = 2'b01; br_tgt[8'h22] = 8'h50;
    do_reset();
    for (int i = 0; i < 6; i++) push(8'(i), 1'b0, -1);
    push(8'h40, 1, -1); push(8'h41, 0, -1); push(8'h10, 1, -1); push(8'h11, 0, -1);
    push(8'h20, 1, -1); push(8'h21, 0, -1); push(8'h22, 0, -1);
    wait_drain(300);
    wait_halt(40, 13);

    // Slow memory and decoder, PC wrap from 0xFF to 0x00.
    clear_prog();
    noisy = 1'b0; br_delay = 0; ack_delay = 4; ready_delay = 2;
    mem[0] = mk(0, 1, 0); br_op[0] = 2'b01; br_tgt[0] = 8'hFE;
    do_reset();
    push(8'h00, 0, -1); push(8'hFE, 1, -1); push(8'hFF, 0, -1); push(8'h00, 0, -1);
    for (int i = 0; i < 200 && exp_q.size() > 2; i++) @(negedge clk);
    mem[0] = mk(0, 0, 1);
    wait_drain(200);
    wait_halt(40, 4);

    // Reset while resolving, with a taken branch presented in the reset cycle.
    clear_prog();
    ack_delay = 0; ready_delay = 0; br_delay = 50;
    mem[2] = mk(2, 1, 0); br_op[2] = 2'b01; br_tgt[2] = 8'h33;
    do_reset();
    push(8'h00, 0, -1); push(8'h01, 0, -1); push(8'h02, 0, -1);
    wait_drain(50);
    repeat (4) @(posedge clk);
    @(posedge clk); #2;
    force_br = 1'b1;
    mem[0] = mk(0, 0, 1);
    do_reset();
    push(8'h00, 0, 2);
    wait_drain(20);
    wait_halt(20, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
